// File: rtl/div16_iter_pkg.sv
// div16_iter_pkg: shared state encoding, saturation constants and sign helper for the divider.
package div16_iter_pkg;
    localparam int WIDTH = 16;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_e;
    localparam logic [WIDTH-1:0] SAT_POS  = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG  = 16'h8000;
    localparam logic [WIDTH-1:0] DIV0_UNS = 16'hFFFF;
    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/div16_iter_if.sv
// div16_iter_if: request/result bundle between the execute stage and the divider.
interface div16_iter_if;
    import div16_iter_pkg::*;
    logic             start, signed_op, busy, done, div_by_zero;
    logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
    modport master(output start, signed_op, dividend, divisor,
                   input busy, done, quotient, remainder, div_by_zero);
    modport slave(input start, signed_op, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div16_iter_div_step.sv
// div_step: one restoring-division iteration (shift, trial subtract, select).
module div_step import div16_iter_pkg::*; (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH+1:0] sh, trial;
    assign sh    = {rem_i, quo_i[WIDTH-1]};
    assign trial = sh - {2'b0, divisor_i};
    // trial MSB set means the subtraction borrowed: keep the shifted remainder
    assign rem_o = trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};
endmodule

// File: rtl/div16_iter.sv
// div16_iter: multi-cycle signed/unsigned restoring divider with saturation and div-by-zero flag.
module div16_iter import div16_iter_pkg::*; (
    input logic clk,
    input logic rst,
    div16_iter_if.slave bus
);
    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, mag_q, mag_d, quo_q, quo_d;
    logic [WIDTH-1:0] qout_q, qout_d, rout_q, rout_d, quo_n;
    logic [WIDTH:0]   rem_q, rem_d, rem_n;
    logic             zero, ovf, dneg, sneg;

    div_step u_step (.rem_i(rem_q), .quo_i(quo_q), .divisor_i(mag_q), .rem_o(rem_n), .quo_o(quo_n));

    assign zero = dvs_q == '0;
    assign dneg = sgn_q & dvd_q[WIDTH-1];
    assign sneg = sgn_q & dvs_q[WIDTH-1];
    // only -32768 / -1 yields a positive magnitude of 0x8000
    assign ovf  = sgn_q & ~qneg_q & quo_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        mag_d   = mag_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = bus.start ? LOAD : IDLE;
                dvd_d   = bus.start ? bus.dividend : dvd_q;
                dvs_d   = bus.start ? bus.divisor : dvs_q;
                sgn_d   = bus.start ? bus.signed_op : sgn_q;
            end
            LOAD: begin
                quo_d   = neg_if(dneg, dvd_q);
                mag_d   = neg_if(sneg, dvs_q);
                rem_d   = '0;
                qneg_d  = dneg ^ sneg;
                rneg_d  = dneg;
                cnt_d   = 5'(WIDTH - 1);
                state_d = zero ? FIX : RUN;
            end
            RUN: begin
                rem_d   = rem_n;
                quo_d   = quo_n;
                cnt_d   = cnt_q - 5'd1;
                state_d = cnt_q == '0 ? FIX : RUN;
            end
            FIX: begin
                qout_d  = zero ? (sgn_q ? (dvd_q[WIDTH-1] ? SAT_NEG : SAT_POS) : DIV0_UNS)
                               : ovf ? SAT_POS : neg_if(qneg_q, quo_q);
                rout_d  = zero ? dvd_q : ovf ? '0 : neg_if(rneg_q, rem_q[WIDTH-1:0]);
                dz_d    = zero;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            mag_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            mag_q   <= mag_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
        end
    end

    assign bus.busy        = state_q inside {LOAD, RUN, FIX};
    assign bus.done        = state_q == DONE;
    assign bus.quotient    = qout_q;
    assign bus.remainder   = rout_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_div16_iter.sv
// tb_div16_iter: directed and random checks of div16_iter against an integer-arithmetic model.
module tb_div16_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] nxt_a, nxt_b;
    logic        nxt_s;

    div16_iter_if bus();
    div16_iter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = b == 16'd0;
        if (z) begin
            q = !s ? 16'hFFFF : (sa < 0 ? 16'h8000 : 16'h7FFF);
            r = a;
        end else if (s && sa == -32768 && sb == -1) begin
            q = 16'h7FFF;
            r = 16'h0000;
        end else if (s) begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag,
                          input bit hammer, input bit chain, input bit pre);
        logic [15:0] eq, er, dq, dr;
        logic        ez, dd;
        int lat, dcyc, dcnt, bbad;
        model(a, b, s, eq, er, ez);
        lat  = ez ? 3 : 19;
        dcyc = 0;
        dcnt = 0;
        bbad = 0;
        dq   = 'x;
        dr   = 'x;
        dd   = 1'bx;
        if (!pre) begin
            @(posedge clk); #1;
            bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.signed_op = s;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dcnt++;
                dcyc = k;
                dq = bus.quotient;
                dr = bus.remainder;
                dd = bus.div_by_zero;
            end
            if (bus.busy !== (k < lat)) bbad++;
            if (hammer) begin
                bus.start = k < lat;
                {bus.dividend, bus.divisor} = $urandom;
                bus.signed_op = 1'($urandom);
            end
            if (chain && k == lat - 1) begin
                bus.start = 1'b1; bus.dividend = nxt_a; bus.divisor = nxt_b; bus.signed_op = nxt_s;
            end
            if (chain && k == lat) break;
        end
        chk({tag, "_done_cycle"}, 16'(dcyc), 16'(lat));
        chk({tag, "_done_count"}, 16'(dcnt), 16'd1);
        chk({tag, "_busy_profile"}, 16'(bbad), 16'd0);
        chk({tag, "_quotient"}, dq, eq);
        chk({tag, "_remainder"}, dr, er);
        chk({tag, "_div0"}, 16'(dd), 16'(ez));
        chk({tag, "_held_q"}, bus.quotient, eq);
    endtask

    initial begin
        int dn;
        logic [15:0] ra, rb;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_q", bus.quotient, 16'd0);
        chk("rst_r", bus.remainder, 16'd0);
        chk("rst_dz", 16'(bus.div_by_zero), 16'd0);

        run_op(16'd100, 16'd7, 1'b0, "u100_7", 0, 0, 0);
        chk("u100_7_q_const", bus.quotient, 16'd14);
        chk("u100_7_r_const", bus.remainder, 16'd2);
        run_op(16'hFFF9, 16'd2, 1'b1, "sm7_2", 0, 0, 0);
        chk("sm7_2_q_const", bus.quotient, 16'hFFFD);
        chk("sm7_2_r_const", bus.remainder, 16'hFFFF);
        run_op(16'd7, 16'hFFFE, 1'b1, "s7_m2", 0, 0, 0);
        chk("s7_m2_q_const", bus.quotient, 16'hFFFD);
        chk("s7_m2_r_const", bus.remainder, 16'd1);
        run_op(16'd5, 16'd0, 1'b0, "u5_0", 0, 0, 0);
        chk("u5_0_q_const", bus.quotient, 16'hFFFF);
        chk("u5_0_r_const", bus.remainder, 16'd5);
        run_op(16'hFFFB, 16'd0, 1'b1, "sm5_0", 0, 0, 0);
        chk("sm5_0_q_const", bus.quotient, 16'h8000);
        run_op(16'h0000, 16'd0, 1'b1, "s0_0", 0, 0, 0);
        chk("s0_0_q_const", bus.quotient, 16'h7FFF);
        run_op(16'h8000, 16'hFFFF, 1'b1, "s_ovf", 0, 0, 0);
        chk("s_ovf_q_const", bus.quotient, 16'h7FFF);
        chk("s_ovf_r_const", bus.remainder, 16'd0);
        run_op(16'hFFFF, 16'd1, 1'b0, "uffff_1", 0, 0, 0);
        chk("uffff_1_q_const", bus.quotient, 16'hFFFF);
        run_op(16'h8000, 16'd1, 1'b1, "s_min_1", 0, 0, 0);
        run_op(16'd1000, 16'd33, 1'b0, "hammer", 1, 0, 0);
        chk("hammer_q_const", bus.quotient, 16'd30);

        nxt_a = 16'hD8F1; nxt_b = 16'd37; nxt_s = 1'b1;
        run_op(16'd12345, 16'd100, 1'b0, "chain1", 0, 1, 0);
        run_op(nxt_a, nxt_b, nxt_s, "chain2", 0, 0, 1);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 16'd40000; bus.divisor = 16'd3; bus.signed_op = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 16'(bus.busy), 16'd0);
        chk("midrst_done", 16'(bus.done), 16'd0);
        chk("midrst_q", bus.quotient, 16'd0);
        chk("midrst_r", bus.remainder, 16'd0);
        chk("midrst_dz", 16'(bus.div_by_zero), 16'd0);
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("midrst_no_done", 16'(dn), 16'd0);
        run_op(16'd40000, 16'd3, 1'b0, "after_rst", 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'd0 :
                 ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
            if ($urandom_range(0, 1) == 0) rb = -rb;
            run_op(ra, rb, 1'($urandom), $sformatf("rnd%0d", i), 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
